// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave FSM state type.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StLast,
        StErr1,
        StErr2
    } state_e;

endpackage

// File: rtl/ahb_sram_slave_p_if.sv
// AHB-Lite slave-side bus bundle: master drives address/control/wdata, slave returns ready/resp/rdata.
interface ahb_sram_slave_p_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic              hsel;
    logic [ADDR_W-1:0] haddr;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [3:0]        hprot;
    logic [1:0]        htrans;
    logic              hmastlock;
    logic              hready;
    logic [DATA_W-1:0] hwdata;
    logic              hreadyout;
    logic              hresp;
    logic [DATA_W-1:0] hrdata;

    modport master (
        output hsel, haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hready, hwdata,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hready, hwdata,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_sram_array.sv
// Word-organised storage with per-byte write strobes and a combinational read port.
module ahb_sram_array #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH_WORDS = 256,
    localparam int unsigned STRB_W     = DATA_W / 8,
    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic              we_i,
    input  logic [STRB_W-1:0] wstrb_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (wstrb_i[b]) begin
                    mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/ahb_sram_slave_p.sv
// Parametrised AHB-Lite SRAM target: wait states, byte-lane writes, pipelined accepts and
// a two-cycle ERROR response for out-of-range, oversized or misaligned transfers.
module ahb_sram_slave_p
    import ahb_pkg::*;
#(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DEPTH_WORDS = 256,
    parameter int unsigned       WAIT_STATES = 0,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
    input logic               hclk,
    input logic               hresetn,
    ahb_sram_slave_p_if.slave bus
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned LANE_W = $clog2(STRB_W);
    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);

    function automatic logic [STRB_W-1:0] byte_strobes(input logic [2:0]        size,
                                                      input logic [LANE_W-1:0] lane);
        logic [STRB_W-1:0] base;
        case (size)
            HSIZE_BYTE:  base = STRB_W'(8'h01);
            HSIZE_HALF:  base = STRB_W'(8'h03);
            HSIZE_WORD:  base = STRB_W'(8'h0F);
            HSIZE_DWORD: base = STRB_W'(8'hFF);
            default:     base = '0;
        endcase
        return base << lane;
    endfunction

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [2:0]        size_q, size_d;
    logic              write_q, write_d;
    logic              hreadyout_q, hreadyout_d;
    logic              hresp_q, hresp_d;

    logic [ADDR_W-1:0] offset, word_idx;
    logic              addr_err, accept, can_accept;
    logic              we;
    logic [DATA_W-1:0] rdata;
    logic              unused_ignored;

    assign offset   = bus.haddr - BASE_ADDR;
    assign word_idx = offset >> LANE_W;
    assign addr_err = (bus.haddr < BASE_ADDR)
                    || (word_idx >= ADDR_W'(DEPTH_WORDS))
                    || (bus.hsize > 3'(LANE_W))
                    || ((bus.haddr & ADDR_W'((32'd1 << bus.hsize) - 32'd1)) != '0);

    // Only states whose data phase is completing this cycle may take a new address phase.
    assign can_accept = (state_q == StIdle) || (state_q == StLast) || (state_q == StErr2);
    assign accept     = can_accept && bus.hsel && bus.hready
                        && (bus.htrans != HTRANS_IDLE) && (bus.htrans != HTRANS_BUSY);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        size_d  = size_q;
        write_d = write_q;
        case (state_q)
            StIdle, StLast, StErr2: begin
                state_d = StIdle;
                if (accept) begin
                    idx_d   = word_idx[IDX_W-1:0];
                    lane_d  = offset[LANE_W-1:0];
                    size_d  = bus.hsize;
                    write_d = bus.hwrite;
                    if (addr_err) begin
                        state_d = StErr1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = StWait;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end else begin
                        state_d = StLast;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StLast;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StErr1:  state_d = StErr2;
            default: state_d = StIdle;
        endcase
        hreadyout_d = !((state_d == StWait) || (state_d == StErr1));
        hresp_d     = ((state_d == StErr1) || (state_d == StErr2)) ? HRESP_ERROR : HRESP_OKAY;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            lane_q      <= '0;
            size_q      <= '0;
            write_q     <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            lane_q      <= lane_d;
            size_q      <= size_d;
            write_q     <= write_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    assign we = (state_q == StLast) && write_q;

    ahb_sram_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk_i   (hclk),
        .idx_i   (idx_q),
        .we_i    (we),
        .wstrb_i (byte_strobes(size_q, lane_q)),
        .wdata_i (bus.hwdata),
        .rdata_o (rdata)
    );

    assign bus.hreadyout = hreadyout_q;
    assign bus.hresp     = hresp_q;
    assign bus.hrdata    = ((state_q == StLast) && !write_q) ? rdata : '0;

    assign unused_ignored = ^{bus.hburst, bus.hprot, bus.hmastlock};

endmodule

// File: tb/tb_ahb_sram_slave_p.sv
// Bench for ahb_sram_slave_p: a zero-wait and a two-wait-state instance behind a small bus mux,
// driven by a pipelined master and checked by a scoreboard fed from vector tables.
module tb_ahb_sram_slave_p;
    import ahb_pkg::*;

    typedef struct {
        bit        sel;
        bit [1:0]  trans;
        bit        wr;
        bit [2:0]  size;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [31:0] exp_rdata;
        bit        exp_err;
    } xfer_t;

    typedef struct {
        bit [31:0] rdata;
        bit        err;
        int        waits;
    } exp_t;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        use_w;
    logic        hsel_tb, hwrite_tb;
    logic [1:0]  htrans_tb;
    logic [2:0]  hsize_tb;
    logic [31:0] haddr_tb, hwdata_tb;
    logic        ready_obs, resp_obs;
    logic [31:0] rdata_obs;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   dp_cycles = 0;
    exp_t sb[$];

    always #5 hclk = ~hclk;

    ahb_sram_slave_p_if #(.DATA_W(32), .ADDR_W(32)) bus0 ();
    ahb_sram_slave_p_if #(.DATA_W(32), .ADDR_W(32)) bus1 ();

    assign ready_obs = use_w ? bus1.hreadyout : bus0.hreadyout;
    assign resp_obs  = use_w ? bus1.hresp : bus0.hresp;
    assign rdata_obs = use_w ? bus1.hrdata : bus0.hrdata;

    assign bus0.hsel = hsel_tb & ~use_w;
    assign bus1.hsel = hsel_tb & use_w;
    assign bus0.haddr = haddr_tb;      assign bus1.haddr = haddr_tb;
    assign bus0.hwrite = hwrite_tb;    assign bus1.hwrite = hwrite_tb;
    assign bus0.hsize = hsize_tb;      assign bus1.hsize = hsize_tb;
    assign bus0.hburst = 3'd0;         assign bus1.hburst = 3'd0;
    assign bus0.hprot = 4'd0;          assign bus1.hprot = 4'd0;
    assign bus0.htrans = htrans_tb;    assign bus1.htrans = htrans_tb;
    assign bus0.hmastlock = 1'b0;      assign bus1.hmastlock = 1'b0;
    assign bus0.hready = ready_obs;    assign bus1.hready = ready_obs;
    assign bus0.hwdata = hwdata_tb;    assign bus1.hwdata = hwdata_tb;

    ahb_sram_slave_p #(
        .DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(256), .WAIT_STATES(0), .BASE_ADDR(32'h0)
    ) u_dut0 (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus0)
    );

    ahb_sram_slave_p #(
        .DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(256), .WAIT_STATES(2), .BASE_ADDR(32'h1000)
    ) u_dut1 (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic xfer_t mk(bit wr, bit [2:0] size, bit [31:0] addr, bit [31:0] wdata,
                                 bit [31:0] exp_rdata, bit exp_err,
                                 bit [1:0] trans = HTRANS_NONSEQ, bit sel = 1'b1);
        xfer_t x;
        x.sel = sel; x.trans = trans; x.wr = wr; x.size = size; x.addr = addr;
        x.wdata = wdata; x.exp_rdata = exp_rdata; x.exp_err = exp_err;
        return x;
    endfunction

    // Pipelined master: address of beat i overlaps the data phase of beat i-1.
    task automatic run(input xfer_t xs[$]);
        for (int i = 0; i <= xs.size(); i++) begin
            int guard = 0;
            if (i < xs.size()) begin
                hsel_tb   = xs[i].sel;
                htrans_tb = xs[i].trans;
                hwrite_tb = xs[i].wr;
                hsize_tb  = xs[i].size;
                haddr_tb  = xs[i].addr;
                if (xs[i].sel && xs[i].trans[1]) begin
                    exp_t e;
                    e.err   = xs[i].exp_err;
                    e.rdata = (xs[i].wr || xs[i].exp_err) ? 32'h0 : xs[i].exp_rdata;
                    e.waits = xs[i].exp_err ? 1 : (use_w ? 2 : 0);
                    sb.push_back(e);
                end
            end else begin
                hsel_tb   = 1'b0;
                htrans_tb = HTRANS_IDLE;
            end
            while (1) begin
                @(negedge hclk);
                if (ready_obs) break;
                guard++;
                if (guard > 64) begin
                    check("ready_timeout", 32'(ready_obs), 32'd1);
                    break;
                end
            end
            @(posedge hclk);
            #1;
            if (i < xs.size()) hwdata_tb = xs[i].wdata;
        end
    endtask

    // Data-phase monitor: pops the scoreboard when an address phase is about to be accepted.
    initial begin
        exp_t cur;
        bit   dp_active = 1'b0;
        int   wcnt = 0;
        forever begin
            @(negedge hclk);
            if (!hresetn) begin
                sb.delete();
                dp_active = 1'b0;
                wcnt = 0;
                continue;
            end
            if (dp_active) begin
                dp_cycles++;
                if (!ready_obs) begin
                    wcnt++;
                    check("wait_resp", 32'(resp_obs), 32'(cur.err));
                    check("wait_rdata", rdata_obs, 32'h0);
                end else begin
                    check("done_resp", 32'(resp_obs), 32'(cur.err));
                    check("done_rdata", rdata_obs, cur.rdata);
                    check("done_waits", 32'(wcnt), 32'(cur.waits));
                    dp_active = 1'b0;
                end
            end else begin
                check("idle_ready", 32'(ready_obs), 32'd1);
                check("idle_resp", 32'(resp_obs), 32'd0);
                check("idle_rdata", rdata_obs, 32'h0);
            end
            if (ready_obs && hsel_tb && (htrans_tb == HTRANS_NONSEQ || htrans_tb == HTRANS_SEQ))
            begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    cur = sb.pop_front();
                    dp_active = 1'b1;
                    wcnt = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        xfer_t tab0[$];
        xfer_t tab1[$];
        xfer_t seq[$];
        xfer_t post[$];
        int    c0;

        hresetn = 1'b0; use_w = 1'b0; hsel_tb = 1'b0; htrans_tb = HTRANS_IDLE;
        hwrite_tb = 1'b0; hsize_tb = HSIZE_WORD; haddr_tb = '0; hwdata_tb = '0;

        tab0.push_back(mk(1, HSIZE_WORD, 32'h100, 32'hDEADBEEF, 0, 0));
        tab0.push_back(mk(0, HSIZE_WORD, 32'h100, 0, 32'hDEADBEEF, 0));
        tab0.push_back(mk(1, HSIZE_WORD, 32'h000, 32'h11223344, 0, 0));
        tab0.push_back(mk(1, HSIZE_BYTE, 32'h002, 32'hFFAAFFFF, 0, 0));
        tab0.push_back(mk(1, HSIZE_HALF, 32'h000, 32'hEEEE5566, 0, 0));
        tab0.push_back(mk(0, HSIZE_WORD, 32'h000, 0, 32'h11AA5566, 0));
        tab0.push_back(mk(0, HSIZE_WORD, 32'h400, 0, 0, 1));
        tab0.push_back(mk(1, HSIZE_WORD, 32'h002, 32'h12345678, 0, 1));
        tab0.push_back(mk(0, HSIZE_WORD, 32'h000, 0, 32'h11AA5566, 0));
        tab0.push_back(mk(1, HSIZE_WORD, 32'h3FC, 32'hCAFEF00D, 0, 0));
        tab0.push_back(mk(0, HSIZE_WORD, 32'h3FC, 0, 32'hCAFEF00D, 0));
        tab0.push_back(mk(1, HSIZE_DWORD, 32'h000, 32'h0, 0, 1));
        tab0.push_back(mk(1, HSIZE_WORD, 32'h004, 32'hA5A5A5A5, 0, 0));
        tab0.push_back(mk(1, HSIZE_HALF, 32'h006, 32'h77880000, 0, 0));
        tab0.push_back(mk(1, HSIZE_HALF, 32'h005, 32'h11111111, 0, 1));
        tab0.push_back(mk(1, HSIZE_BYTE, 32'h007, 32'h99000000, 0, 0));
        tab0.push_back(mk(0, HSIZE_WORD, 32'h004, 0, 32'h9988A5A5, 0));
        tab0.push_back(mk(1, HSIZE_WORD, 32'h000, 32'h0, 0, 0, HTRANS_IDLE));
        tab0.push_back(mk(1, HSIZE_WORD, 32'h000, 32'h0, 0, 0, HTRANS_BUSY));
        tab0.push_back(mk(1, HSIZE_WORD, 32'h000, 32'h0, 0, 0, HTRANS_NONSEQ, 1'b0));
        tab0.push_back(mk(0, HSIZE_WORD, 32'h000, 0, 32'h11AA5566, 0));
        tab0.push_back(mk(0, HSIZE_BYTE, 32'h004, 0, 32'h9988A5A5, 0));

        tab1.push_back(mk(1, HSIZE_WORD, 32'h1000, 32'h01010101, 0, 0));
        tab1.push_back(mk(1, HSIZE_WORD, 32'h1004, 32'h02020202, 0, 0));
        tab1.push_back(mk(1, HSIZE_WORD, 32'h1008, 32'h03030303, 0, 0));
        tab1.push_back(mk(1, HSIZE_WORD, 32'h100C, 32'h04040404, 0, 0));
        tab1.push_back(mk(0, HSIZE_WORD, 32'h0FFC, 0, 0, 1));
        tab1.push_back(mk(0, HSIZE_WORD, 32'h1400, 0, 0, 1));
        tab1.push_back(mk(1, HSIZE_WORD, 32'h13FC, 32'h5A5A5A5A, 0, 0));
        tab1.push_back(mk(0, HSIZE_WORD, 32'h13FC, 0, 32'h5A5A5A5A, 0));
        tab1.push_back(mk(0, HSIZE_WORD, 32'h1004, 0, 32'h02020202, 0));

        seq.push_back(mk(0, HSIZE_WORD, 32'h1000, 0, 32'h01010101, 0, HTRANS_NONSEQ));
        seq.push_back(mk(0, HSIZE_WORD, 32'h1004, 0, 32'h02020202, 0, HTRANS_SEQ));
        seq.push_back(mk(0, HSIZE_WORD, 32'h1008, 0, 32'h03030303, 0, HTRANS_SEQ));
        seq.push_back(mk(0, HSIZE_WORD, 32'h100C, 0, 32'h04040404, 0, HTRANS_SEQ));

        post.push_back(mk(0, HSIZE_WORD, 32'h1000, 0, 32'h01010101, 0));

        repeat (3) @(posedge hclk);
        #1;
        check("rst_ready0", 32'(bus0.hreadyout), 32'd1);
        check("rst_resp0", 32'(bus0.hresp), 32'd0);
        check("rst_rdata0", bus0.hrdata, 32'h0);
        check("rst_ready1", 32'(bus1.hreadyout), 32'd1);
        check("rst_resp1", 32'(bus1.hresp), 32'd0);
        check("rst_rdata1", bus1.hrdata, 32'h0);
        hresetn = 1'b1;
        @(posedge hclk);
        #1;

        run(tab0);
        use_w = 1'b1;
        run(tab1);
        c0 = dp_cycles;
        run(seq);
        check("seq_cycles", 32'(dp_cycles - c0), 32'd12);

        // Abort a waited write with reset; the old word must survive.
        hsel_tb = 1'b1; htrans_tb = HTRANS_NONSEQ; hwrite_tb = 1'b1;
        hsize_tb = HSIZE_WORD; haddr_tb = 32'h1000;
        begin
            exp_t e;
            e.err = 1'b0; e.rdata = 32'h0; e.waits = 2;
            sb.push_back(e);
        end
        @(posedge hclk);
        #1;
        hsel_tb = 1'b0; htrans_tb = HTRANS_IDLE; hwdata_tb = 32'hBADBAD00;
        @(negedge hclk);
        check("rst_pre_wait", 32'(ready_obs), 32'd0);
        #2 hresetn = 1'b0;
        #1;
        check("rst_mid_ready", 32'(ready_obs), 32'd1);
        check("rst_mid_resp", 32'(resp_obs), 32'd0);
        check("rst_mid_rdata", rdata_obs, 32'h0);
        repeat (2) @(posedge hclk);
        #1 hresetn = 1'b1;
        @(posedge hclk);
        #1;
        run(post);

        repeat (2) @(posedge hclk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
